// File: rtl/ccu_frame_packer.sv
// CCU frame packer: on request, drains an FWFT event FIFO into a header, paired payload words and a trailer.
// Trailer checksum is built only when CCU_FRAME_CHECKSUM_EN is defined; otherwise trailer [31:0] is zero.
module ccu_frame_packer #(
   parameter  int IN_W      = 32,
   parameter  int MAX_WORDS = 256,
   localparam int OUT_W     = 2 * IN_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [23:0]      run_number,
   input  logic [31:0]      orbit_number,
   input  logic [IN_W-1:0]  fifo_data,
   input  logic             fifo_empty,
   output logic             fifo_rd_en,
   input  logic             transmit_request,
   output logic [OUT_W-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
   output logic             transmit_complete,
   output logic [15:0]      word_count
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR, S_LO, S_HI, S_EMIT, S_TRL, S_DONE
   } state_t;

   localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

   state_t          state;
   logic [IN_W-1:0] lo_word;
   logic            odd_flag;
   logic            end_mark;
   logic            can_pop;
   logic            accept;
   logic [31:0]     checksum_cur;
   logic [31:0]     checksum_next;

   function automatic logic [OUT_W-1:0] header_word(input logic [23:0] run, input logic [31:0] orbit);
      logic [OUT_W-1:0] w;
      w       = '0;
      w[63:0] = {8'hA5, run, orbit};
      return w;
   endfunction

   function automatic logic [OUT_W-1:0] trailer_word(input logic odd, input logic [15:0] cnt,
                                                     input logic [31:0] cs);
      logic [OUT_W-1:0] w;
      w       = '0;
      w[63:0] = {8'h5A, 7'b0, odd, cnt, cs};
      return w;
   endfunction

   assign can_pop = !fifo_empty && (word_count < MAX_CNT);
   assign accept  = out_valid && out_ready;

   // The pop strobe must coincide with the edge that latches the FIFO head, so it is decoded, not registered.
   assign fifo_rd_en = ((state == S_LO) || (state == S_HI)) && can_pop;

`ifdef CCU_FRAME_CHECKSUM_EN
   localparam int SLICES = (OUT_W + 31) / 32;

   logic [31:0] checksum;

   function automatic logic [31:0] fold(input logic [OUT_W-1:0] w);
      logic [SLICES*32-1:0] p;
      logic [31:0]          r;
      p            = '0;
      p[OUT_W-1:0] = w;
      r            = '0;
      for (int i = 0; i < SLICES; i++) r ^= p[i*32 +: 32];
      return r;
   endfunction

   assign checksum_cur  = checksum;
   assign checksum_next = checksum ^ fold(out_data);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         checksum <= '0;
      end else if ((state == S_IDLE) && transmit_request) begin
         checksum <= '0;
      end else if ((state == S_EMIT) && out_ready) begin
         checksum <= checksum_next;
      end
   end
`else
   assign checksum_cur  = '0;
   assign checksum_next = '0;
`endif

   // NOTE: all state and output registers use non-blocking assignments so every branch reads pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= S_IDLE;
         lo_word           <= '0;
         odd_flag          <= 1'b0;
         end_mark          <= 1'b0;
         word_count        <= '0;
         out_data          <= '0;
         out_valid         <= 1'b0;
         busy              <= 1'b0;
         transmit_complete <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (transmit_request) begin
                  word_count <= '0;
                  odd_flag   <= 1'b0;
                  end_mark   <= 1'b0;
                  busy       <= 1'b1;
                  out_data   <= header_word(run_number, orbit_number);
                  out_valid  <= 1'b1;
                  state      <= S_HDR;
               end
            end
            S_HDR: begin
               if (accept) begin
                  out_valid <= 1'b0;
                  state     <= S_LO;
               end
            end
            S_LO: begin
               if (can_pop) begin
                  lo_word    <= fifo_data;
                  word_count <= word_count + 16'd1;
                  state      <= S_HI;
               end else begin
                  out_data  <= trailer_word(odd_flag, word_count, checksum_cur);
                  out_valid <= 1'b1;
                  state     <= S_TRL;
               end
            end
            S_HI: begin
               if (can_pop) begin
                  out_data   <= {fifo_data, lo_word};
                  word_count <= word_count + 16'd1;
               end else begin
                  out_data <= {{IN_W{1'b0}}, lo_word};
                  odd_flag <= 1'b1;
                  end_mark <= 1'b1;
               end
               out_valid <= 1'b1;
               state     <= S_EMIT;
            end
            S_EMIT: begin
               if (accept) begin
                  if (end_mark) begin
                     // Trailer carries the checksum including the word accepted on this edge.
                     out_data <= trailer_word(odd_flag, word_count, checksum_next);
                     state    <= S_TRL;
                  end else begin
                     out_valid <= 1'b0;
                     state     <= S_LO;
                  end
               end
            end
            S_TRL: begin
               if (accept) begin
                  out_valid         <= 1'b0;
                  busy              <= 1'b0;
                  transmit_complete <= 1'b1;
                  state             <= S_DONE;
               end
            end
            S_DONE: begin
               transmit_complete <= 1'b0;
               state             <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
